// File: rtl/dds_pkg.sv
// Shared encodings for the sweeping DDS: waveform modes, sweep states, pipeline depth.
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } dds_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } sweep_state_t;

    localparam int DDS_LATENCY = 3;

endpackage

// File: rtl/dds_quarter_sine_rom.sv
// Quarter-wave sine table, synchronous read with a registered output.
// Entry i holds round(A * sin(2*pi*(i+0.5)/2^PHASE_WIDTH)), computed at elaboration.
module dds_quarter_sine_rom #(
    parameter int PHASE_WIDTH = 13,
    parameter int DATA_WIDTH  = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PHASE_WIDTH-3:0] addr,
    output logic [DATA_WIDTH-1:0]  data
);

    localparam int  DEPTH = 2 ** (PHASE_WIDTH - 2);
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = real'(2 ** (DATA_WIDTH - 1) - 1);

    logic [DATA_WIDTH-1:0] lut [DEPTH];

    // The half-entry phase offset keeps the four quadrants exactly odd-symmetric.
    for (genvar i = 0; i < DEPTH; i++) begin : g_lut
        localparam real ANG = 2.0 * PI * (real'(i) + 0.5) / real'(2 ** PHASE_WIDTH);
        localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
        assign lut[i] = VAL[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= lut[addr];
        end
    end

endmodule

// File: rtl/dds_sweep_gen.sv
// Multi-waveform DDS with a linear frequency sweep engine; three-stage output pipeline.
// en freezes the accumulator, sweep and first stage while later stages drain.
module dds_sweep_gen
    import dds_pkg::*;
#(
    parameter int ACC_WIDTH   = 32,
    parameter int PHASE_WIDTH = 13,
    parameter int DATA_WIDTH  = 12,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [ACC_WIDTH-1:0]          freq_start,
    input  logic [ACC_WIDTH-1:0]          freq_stop,
    input  logic [ACC_WIDTH-1:0]          freq_step,
    input  logic [DWELL_WIDTH-1:0]        dwell_cycles,
    input  logic [PHASE_WIDTH-1:0]        phase_offset,
    input  logic                          sweep_loop,
    input  logic                          sweep_start,
    input  logic                          sweep_abort,
    output logic signed [DATA_WIDTH-1:0]  dout,
    output logic                          dout_valid,
    output logic                          sweep_busy,
    output logic                          sweep_done
);

    if (DATA_WIDTH > PHASE_WIDTH - 1) begin : g_width_check
        $error("dds_sweep_gen: DATA_WIDTH must not exceed PHASE_WIDTH-1");
    end

    localparam int AW = PHASE_WIDTH - 2;

    // Sweep engine state
    sweep_state_t           state, state_n;
    logic [ACC_WIDTH-1:0]   freq_cur, freq_cur_n;
    logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_n, dwell_last;
    logic                   reload, reload_n;
    logic                   done_n;
    logic [ACC_WIDTH:0]     freq_sum;

    // Phase accumulator and pipeline
    logic [ACC_WIDTH-1:0]   acc;
    logic [PHASE_WIDTH-1:0] p1, p2;
    dds_mode_t              mode1, mode2;
    logic                   v1, v2;
    logic [AW-1:0]          rom_addr;
    logic [DATA_WIDTH-1:0]  rom_q;
    logic [DATA_WIDTH-1:0]  sample;
    logic [DATA_WIDTH-1:0]  tri_t;

    assign dwell_last = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_WIDTH'(1);
    assign freq_sum   = {1'b0, freq_cur} + {1'b0, freq_step};

    always_comb begin
        state_n     = state;
        freq_cur_n  = freq_cur;
        dwell_cnt_n = dwell_cnt;
        reload_n    = reload;
        done_n      = 1'b0;
        if (sweep_abort) begin
            state_n     = IDLE;
            freq_cur_n  = freq_start;
            dwell_cnt_n = '0;
            reload_n    = 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (state == IDLE) begin
                        freq_cur_n = freq_start;
                    end
                    if (sweep_start) begin
                        state_n     = SWEEP;
                        freq_cur_n  = freq_start;
                        dwell_cnt_n = '0;
                        reload_n    = 1'b0;
                    end
                end
                SWEEP: begin
                    if (en) begin
                        // >= guards against dwell_cycles shrinking below the running count
                        if (dwell_cnt >= dwell_last) begin
                            dwell_cnt_n = '0;
                            if (reload) begin
                                freq_cur_n = freq_start;
                                reload_n   = 1'b0;
                            end else if (freq_sum >= {1'b0, freq_stop}) begin
                                freq_cur_n = freq_stop;
                                done_n     = 1'b1;
                                if (sweep_loop) begin
                                    reload_n = 1'b1;
                                end else begin
                                    state_n = HOLD;
                                end
                            end else begin
                                freq_cur_n = freq_sum[ACC_WIDTH-1:0];
                            end
                        end else begin
                            dwell_cnt_n = dwell_cnt + DWELL_WIDTH'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            freq_cur   <= '0;
            dwell_cnt  <= '0;
            reload     <= 1'b0;
            sweep_done <= 1'b0;
            sweep_busy <= 1'b0;
        end else begin
            state      <= state_n;
            freq_cur   <= freq_cur_n;
            dwell_cnt  <= dwell_cnt_n;
            reload     <= reload_n;
            sweep_done <= done_n;
            sweep_busy <= (state_n == SWEEP);
        end
    end

    // Odd quadrants read the table backwards
    assign rom_addr = p1[PHASE_WIDTH-2] ? ~p1[AW-1:0] : p1[AW-1:0];

    dds_quarter_sine_rom #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (rom_addr),
        .data (rom_q)
    );

    always_comb begin
        sample = '0;
        tri_t  = p2[PHASE_WIDTH-2 -: DATA_WIDTH];
        case (mode2)
            MODE_SINE:   sample = p2[PHASE_WIDTH-1] ? ~rom_q : rom_q;
            MODE_SQUARE: sample = p2[PHASE_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            MODE_TRI: begin
                if (p2[PHASE_WIDTH-1]) begin
                    tri_t = ~tri_t;
                end
                sample = {~tri_t[DATA_WIDTH-1], tri_t[DATA_WIDTH-2:0]};
            end
            MODE_SAW:    sample = {~p2[PHASE_WIDTH-1], p2[PHASE_WIDTH-2 -: DATA_WIDTH-1]};
            default:     sample = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            p1         <= '0;
            mode1      <= MODE_SINE;
            v1         <= 1'b0;
            p2         <= '0;
            mode2      <= MODE_SINE;
            v2         <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            v1         <= en;
            v2         <= v1;
            dout_valid <= v2;
            if (en) begin
                acc   <= acc + freq_cur;
                p1    <= acc[ACC_WIDTH-1 -: PHASE_WIDTH] + phase_offset;
                mode1 <= dds_mode_t'(mode);
            end
            // Mode rides with its phase so a mode change never splices two waveforms
            p2    <= p1;
            mode2 <= mode1;
            if (v2) begin
                dout <= sample;
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_gen.sv
// Directed bench for dds_sweep_gen: waveform sample table, sine scan, freeze and sweep sequences.
module tb_dds_sweep_gen;
    import dds_pkg::*;

    logic               clk = 1'b0;
    logic               rst, en, sweep_loop, sweep_start, sweep_abort;
    logic [1:0]         mode;
    logic [31:0]        freq_start, freq_stop, freq_step;
    logic [15:0]        dwell_cycles;
    logic [12:0]        phase_offset;
    logic signed [11:0] dout;
    logic               dout_valid, sweep_busy, sweep_done;

    int errors = 0;
    int checks = 0;

    dds_sweep_gen dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .freq_start   (freq_start),
        .freq_stop    (freq_stop),
        .freq_step    (freq_step),
        .dwell_cycles (dwell_cycles),
        .phase_offset (phase_offset),
        .sweep_loop   (sweep_loop),
        .sweep_start  (sweep_start),
        .sweep_abort  (sweep_abort),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .sweep_busy   (sweep_busy),
        .sweep_done   (sweep_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  vmode;
        logic [12:0] voff;
        int          k;
        int          exp;
        string       name;
    } vec_t;

    vec_t vecs[17];
    int   fexp[13];
    int   k_now;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; sweep_start = 1'b0; sweep_abort = 1'b0;
        step();
        step();
    endtask

    // Reset, program a tone at 2^20 and run until sample 0 sits on dout
    task automatic start_run(input logic [1:0] m, input logic [12:0] off);
        do_reset();
        mode = m; phase_offset = off; freq_start = 32'h0010_0000;
        rst = 1'b0;
        step();
        en = 1'b1;
        repeat (DDS_LATENCY - 1) step();
        check("valid_before_latency", dout_valid, 0);
        step();
        check("valid_at_latency", dout_valid, 1);
        k_now = 0;
    endtask

    function automatic int sine_model(input int p);
        int q, i, idx, v;
        q   = (p >> 11) & 3;
        i   = p & 2047;
        idx = (q & 1) ? 2047 - i : i;
        v   = $rtoi(2047.0 * $sin(2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / 8192.0) + 0.5);
        return (q & 2) ? -v - 1 : v;
    endfunction

    initial begin
        mode = 2'd3; phase_offset = '0; freq_start = '0; freq_stop = '0; freq_step = '0;
        dwell_cycles = '0; sweep_loop = 1'b0;
        do_reset();
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", sweep_busy, 0);
        check("rst_done", sweep_done, 0);
        check("rst_freq_cur", dut.freq_cur, 0);

        // Waveform samples at 2^20 per step: sample k has phase offset + 2k
        vecs[0]  = '{2'd3, 13'd0,    0,    -2048, "saw_k0"};
        vecs[1]  = '{2'd3, 13'd0,    1,    -2047, "saw_k1"};
        vecs[2]  = '{2'd3, 13'd0,    2,    -2046, "saw_k2"};
        vecs[3]  = '{2'd3, 13'd0,    2047, -1,    "saw_k2047"};
        vecs[4]  = '{2'd3, 13'd0,    2048, 0,     "saw_k2048"};
        vecs[5]  = '{2'd3, 13'd3,    0,    -2047, "saw_off3"};
        vecs[6]  = '{2'd0, 13'd0,    0,    1,     "sine_k0"};
        vecs[7]  = '{2'd0, 13'd0,    1023, 2047,  "sine_peak_a"};
        vecs[8]  = '{2'd0, 13'd0,    1024, 2047,  "sine_peak_b"};
        vecs[9]  = '{2'd0, 13'd0,    2048, -2,    "sine_half"};
        vecs[10] = '{2'd0, 13'd0,    3072, -2048, "sine_trough"};
        vecs[11] = '{2'd1, 13'd4096, 0,    -2048, "square_k0"};
        vecs[12] = '{2'd1, 13'd4096, 2048, 2047,  "square_k2048"};
        vecs[13] = '{2'd2, 13'd0,    0,    -2048, "tri_k0"};
        vecs[14] = '{2'd2, 13'd0,    1024, 0,     "tri_k1024"};
        vecs[15] = '{2'd2, 13'd0,    2047, 2046,  "tri_k2047"};
        vecs[16] = '{2'd2, 13'd0,    2048, 2047,  "tri_k2048"};

        for (int i = 0; i < 17; i++) begin
            if (i == 0 || vecs[i].vmode != mode || vecs[i].voff != phase_offset || vecs[i].k < k_now)
                start_run(vecs[i].vmode, vecs[i].voff);
            while (k_now < vecs[i].k) begin
                step();
                k_now++;
            end
            check(vecs[i].name, dout, vecs[i].exp);
        end

        // Full-cycle sine scan against the LUT formula
        start_run(2'd0, 13'd0);
        for (int k = 0; k < 4096; k++) begin
            check("sine_scan", dout, sine_model((2 * k) % 8192));
            step();
        end

        // Square with a 5-cycle en gap: no skipped samples, dout holds while invalid
        begin
            int k, gaps;
            logic signed [11:0] last;
            start_run(2'd1, 13'd4096);
            k = 0; gaps = 0; last = dout;
            for (int c = 0; c < 4200; c++) begin
                if (k == 4096) break;
                if (dout_valid) begin
                    check("square_seq", dout, (((4096 + 2 * k) % 8192) >= 4096) ? -2048 : 2047);
                    last = dout;
                    k++;
                end else begin
                    check("square_hold", dout, last);
                    gaps++;
                end
                en = !(c >= 1000 && c < 1005);
                step();
            end
            check("square_count", k, 4096);
            check("square_gap", gaps, 5);
        end

        // Single sweep 1000..3000 step 500, dwell 2
        do_reset();
        freq_start = 1000; freq_step = 500; freq_stop = 3000; dwell_cycles = 2; sweep_loop = 1'b0;
        rst = 1'b0; en = 1'b1;
        step();
        check("idle_track", dut.freq_cur, 1000);
        check("idle_busy", sweep_busy, 0);
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        fexp = '{1000, 1000, 1500, 1500, 2000, 2000, 2500, 2500, 3000, 3000, 0, 0, 0};
        for (int j = 0; j < 10; j++) begin
            check("single_freq", dut.freq_cur, fexp[j]);
            check("single_done", sweep_done, (j == 8) ? 1 : 0);
            check("single_busy", sweep_busy, (j < 8) ? 1 : 0);
            step();
        end

        // Looping sweep returns to freq_start after reaching freq_stop
        sweep_loop = 1'b1; sweep_abort = 1'b1;
        step();
        sweep_abort = 1'b0;
        check("abort_from_hold", sweep_busy, 0);
        check("abort_freq", dut.freq_cur, 1000);
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        fexp = '{1000, 1000, 1500, 1500, 2000, 2000, 2500, 2500, 3000, 3000, 1000, 1000, 1500};
        for (int j = 0; j < 13; j++) begin
            check("loop_freq", dut.freq_cur, fexp[j]);
            check("loop_done", sweep_done, (j == 8) ? 1 : 0);
            check("loop_busy", sweep_busy, 1);
            step();
        end
        sweep_abort = 1'b1; sweep_start = 1'b1;
        step();
        sweep_abort = 1'b0; sweep_start = 1'b0;
        check("abort_wins_busy", sweep_busy, 0);
        check("abort_wins_freq", dut.freq_cur, 1000);
        check("abort_wins_done", sweep_done, 0);
        freq_start = 7777;
        step();
        check("idle_follow", dut.freq_cur, 7777);

        // freq_start above freq_stop: first step lands on freq_stop
        freq_start = 5000; sweep_loop = 1'b0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        check("over_s0", dut.freq_cur, 5000);
        step();
        check("over_s1", dut.freq_cur, 5000);
        step();
        check("over_freq", dut.freq_cur, 3000);
        check("over_done", sweep_done, 1);
        check("over_busy", sweep_busy, 0);

        // Dwell 0 steps every cycle; reset mid-sweep clears everything
        freq_start = 100; freq_step = 1; freq_stop = 1000000; dwell_cycles = 0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        check("dwell0_s0", dut.freq_cur, 100);
        step();
        check("dwell0_s1", dut.freq_cur, 101);
        step();
        check("dwell0_s2", dut.freq_cur, 102);
        rst = 1'b1;
        step();
        check("midrst_dout", dout, 0);
        check("midrst_valid", dout_valid, 0);
        check("midrst_busy", sweep_busy, 0);
        check("midrst_done", sweep_done, 0);
        check("midrst_freq", dut.freq_cur, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
